alu_op_sequencer: RTL and testbench

Sequenced front end for the 16-bit ALU datapath: accepts one operation at a time over a valid/ready handshake and computes one of ADD, AND, NAND, SHL, SHR, MUL or DIV. Single-cycle operations complete in one cycle. MUL and DIV share one iterative 16-step unit instead of the combinational `*` and `/`. Results are held under a valid/ready handshake until consumed. The block sits between the instruction/test driver and the result register file.

---
 rtl/alu_seq_pkg.sv | 27 ++
 rtl/alu_iter_muldiv.sv | 97 +++++++++
 rtl/alu_op_sequencer.sv | 125 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM encoding and constants for the ALU operation sequencer.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_SHL  = 3'd3;
    localparam logic [2:0] OP_SHR  = 3'd4;
    localparam logic [2:0] OP_MUL  = 3'd5;
    localparam logic [2:0] OP_DIV  = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [15:0] DIV0_RESULT = 16'hFFFF;
    localparam logic [3:0]  ITER_LAST   = 4'd15;

    // Only MUL and a DIV with a nonzero divisor need the iterative unit.
    function automatic logic needs_iter(input logic [2:0] code, input logic b_is_zero);
        return (code == OP_MUL) || ((code == OP_DIV) && !b_is_zero);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Shared 16-step iterative unit: shift-add multiply (low half) or restoring divide (quotient).
module alu_iter_muldiv
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    logic             run_q,    run_d;
    logic             is_div_q, is_div_d;
    logic [3:0]       cnt_q,    cnt_d;
    logic [WIDTH-1:0] ma_q,     ma_d;
    logic [WIDTH-1:0] mb_q,     mb_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] rem_q,    rem_d;

    logic [WIDTH:0]   rem_sh;
    logic             div_ge;
    logic [WIDTH-1:0] rem_sub;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        run_d    = run_q;
        is_div_d = is_div_q;
        cnt_d    = cnt_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        acc_d    = acc_q;
        rem_d    = rem_q;

        // DIV: ma holds the dividend shifting out MSB-first, mb the divisor.
        // The remainder stays below the divisor, so a WIDTH-bit difference is exact.
        rem_sh  = {rem_q, ma_q[WIDTH-1]};
        div_ge  = (rem_sh >= {1'b0, mb_q});
        rem_sub = rem_sh[WIDTH-1:0] - mb_q;

        if (start) begin
            run_d    = 1'b1;
            is_div_d = is_div;
            cnt_d    = '0;
            ma_d     = a;
            mb_d     = b;
            acc_d    = '0;
            rem_d    = '0;
        end else if (run_q) begin
            if (is_div_q) begin
                rem_d = div_ge ? rem_sub : rem_sh[WIDTH-1:0];
                acc_d = {acc_q[WIDTH-2:0], div_ge};
                ma_d  = ma_q << 1;
            end else begin
                if (mb_q[0]) begin
                    acc_d = acc_q + ma_q;
                end
                ma_d = ma_q << 1;
                mb_d = mb_q >> 1;
            end
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == ITER_LAST) begin
                run_d = 1'b0;
            end
        end
    end

    // Final step: the parent registers acc_d on the same edge the last iteration lands.
    assign done   = run_q && (cnt_q == ITER_LAST);
    assign result = acc_d;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
        end else begin
            run_q    <= run_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU front end: one operation per valid/ready handshake, result held until consumed.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    output logic             busy
);

    localparam logic [SHW-1:0] SH_LIMIT = SHW'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_err_q,  res_err_d;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] single_res;
    logic             single_err;
    logic             iter_op;
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_result;

    assign shamt   = op_b[SHW-1:0];
    assign iter_op = needs_iter(op_code, (op_b == '0));

    always_comb begin
        single_res = '0;
        single_err = 1'b0;
        case (op_code)
            OP_ADD:  single_res = op_a + op_b;
            OP_AND:  single_res = op_a & op_b;
            OP_NAND: single_res = ~(op_a & op_b);
            OP_SHL:  single_res = (shamt >= SH_LIMIT) ? '0 : (op_a << shamt);
            OP_SHR:  single_res = (shamt >= SH_LIMIT) ? '0 : (op_a >> shamt);
            OP_DIV: begin
                // Only reached with a zero divisor; nonzero divisors go to the iterative unit.
                single_res = DIV0_RESULT;
                single_err = 1'b1;
            end
            default: begin
                single_res = '0;
                single_err = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        md_start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    if (iter_op) begin
                        md_start = 1'b1;
                        state_d  = ST_EXEC;
                    end else begin
                        res_data_d = single_res;
                        res_err_d  = single_err;
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_EXEC: begin
                if (md_done) begin
                    res_data_d = md_result;
                    res_err_d  = 1'b0;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
        end
    end

    alu_iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .is_div (op_code == OP_DIV),
        .a      (op_a),
        .b      (op_b),
        .done   (md_done),
        .result (md_result)
    );

    assign op_ready  = (state_q == ST_IDLE);
    assign res_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench: the driver queues hand-computed results, a negedge monitor checks them.
module tb_alu_op_sequencer;

    localparam logic [2:0] C_ADD = 3'd0, C_AND = 3'd1, C_NAND = 3'd2, C_SHL = 3'd3,
                           C_SHR = 3'd4, C_MUL = 3'd5, C_DIV = 3'd6, C_RSVD = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [2:0]  op_code = '0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [15:0] res_data;
    logic        res_err;
    logic        busy;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    bit   pending_acc = 1'b0;
    bit   res_seen = 1'b0;

    alu_op_sequencer #(.WIDTH(16), .SHW(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_code   (op_code),
        .op_a      (op_a),
        .op_b      (op_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Latency is the number of edges from the accepting edge to the first edge that samples res_valid high.
    always @(posedge clk) begin
        cyc++;
        if (pending_acc) accept_cyc = cyc;
        pending_acc = 1'b0;
    end

    always @(negedge clk) begin
        pending_acc = op_valid && op_ready && rst_n;
        if (rst_n && res_valid) begin
            check("op_ready_low_in_done", op_ready, 0);
            if (!res_seen) begin
                res_seen = 1'b1;
                if (sb.size() == 0) begin
                    check("unexpected_result", 32'(sb.size()), 1);
                end else begin
                    cur = sb.pop_front();
                    check({cur.name, "_data"}, res_data, cur.data);
                    check({cur.name, "_err"},  res_err,  cur.err);
                    check({cur.name, "_lat"},  32'(cyc - accept_cyc + 1), 32'(cur.lat));
                end
            end else begin
                check({cur.name, "_hold_data"}, res_data, cur.data);
                check({cur.name, "_hold_err"},  res_err,  cur.err);
            end
        end else begin
            res_seen = 1'b0;
        end
    end

    // Called just after a rising edge with the DUT idle; returns just after the accepting edge.
    task automatic issue(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_d, input logic exp_e, input int lat, input string nm);
        exp_t e;
        e.data = exp_d;
        e.err  = exp_e;
        e.lat  = lat;
        e.name = nm;
        sb.push_back(e);
        op_code  = c;
        op_a     = a;
        op_b     = b;
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        op_code  = 3'($urandom);
        op_a     = 16'($urandom);
        op_b     = 16'($urandom);
        check({nm, "_busy_after_accept"}, busy, 1);
        check({nm, "_ready_after_accept"}, op_ready, 0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0 && !res_valid && op_ready) return;
            @(posedge clk);
            #1;
        end
        check("wait_idle_timeout_pending", 32'(sb.size()), 0);
        sb.delete();
    endtask

    task automatic run_op(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_d, input logic exp_e, input int lat, input string nm);
        issue(c, a, b, exp_d, exp_e, lat, nm);
        wait_idle();
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_op_ready"},  op_ready,  1);
        check({nm, "_res_valid"}, res_valid, 0);
        check({nm, "_busy"},      busy,      0);
        check({nm, "_res_data"},  res_data,  0);
        check({nm, "_res_err"},   res_err,   0);
    endtask

    initial begin
        // Handshake attempted during reset must be ignored.
        op_valid = 1'b1;
        op_code  = C_ADD;
        op_a     = 16'h1111;
        op_b     = 16'h2222;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        op_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("after_release");

        run_op(C_ADD,  16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1,  "add_wrap");
        run_op(C_SHL,  16'd11,   16'd5,    16'h0160, 1'b0, 1,  "shl_5");
        run_op(C_SHL,  16'h0160, 16'd2,    16'h0580, 1'b0, 1,  "shl_2");
        run_op(C_SHR,  16'h8000, 16'd16,   16'h0000, 1'b0, 1,  "shr_16");
        run_op(C_SHR,  16'hF0F0, 16'd4,    16'h0F0F, 1'b0, 1,  "shr_4");
        run_op(C_SHL,  16'h0001, 16'h0020, 16'h0001, 1'b0, 1,  "shl_upper_bits_ignored");
        run_op(C_AND,  16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1,  "and");
        run_op(C_NAND, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1,  "nand");
        run_op(C_MUL,  16'd3,    16'd3,    16'd9,    1'b0, 17, "mul_3x3");
        run_op(C_MUL,  16'h0100, 16'h0100, 16'h0000, 1'b0, 17, "mul_trunc");
        run_op(C_MUL,  16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 17, "mul_max");
        run_op(C_DIV,  16'd100,  16'd7,    16'd14,   1'b0, 17, "div_100_7");
        run_op(C_DIV,  16'hFFFF, 16'd1,    16'hFFFF, 1'b0, 17, "div_by_1");
        run_op(C_DIV,  16'd5,    16'd0,    16'hFFFF, 1'b1, 1,  "div_by_0");
        run_op(C_RSVD, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1,  "opcode_7");

        // Consumer stalls for 5 cycles in DONE; the monitor checks the held values each cycle.
        res_ready = 1'b0;
        issue(C_ADD, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1, "add_stall");
        for (int i = 0; i < 40; i++) begin
            if (res_valid) break;
            @(posedge clk);
            #1;
        end
        repeat (5) @(posedge clk);
        #1;
        check("stall_still_valid", res_valid, 1);
        res_ready = 1'b1;
        wait_idle();

        // Asynchronous reset in the middle of a MUL aborts it.
        issue(C_MUL, 16'h1234, 16'd5, 16'h5B04, 1'b0, 17, "mul_aborted");
        repeat (7) @(posedge clk);
        #1;
        check("abort_busy_before_reset", busy, 1);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("abort_release");
        run_op(C_MUL, 16'd7, 16'd6, 16'd42, 1'b0, 17, "mul_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
